// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload, zero padding, FCS, inter-frame gap.
// Define GMII_TX_FRAMER_FCS_EN to include the CRC-32 FCS generator and FCS state.
//
// state  | meaning
// S_IDLE | waiting for in_val; nothing driven
// S_PRE  | preamble 0x55 being produced
// S_SFD  | start-of-frame delimiter 0xD5 being produced
// S_DATA | in_rdy high, payload bytes forwarded
// S_PAD  | 0x00 fill up to MIN_FRAME
// S_FCS  | four CRC-32 bytes, LSB byte first
// S_IFG  | abort byte (if pending) then IFG_BYTES idle cycles

module gmii_tx_framer #(
    parameter int IFG_BYTES = 12,
    parameter int MIN_FRAME = 60
) (
    input  logic       clk,
    input  logic       arst,
    input  logic [7:0] in_dat,
    input  logic       in_val,
    input  logic       in_last,
    input  logic       in_err,
    output logic       in_rdy,
    output logic [7:0] gmii_tx_dat,
    output logic       gmii_tx_val,
    output logic       gmii_tx_err,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SFD,
        S_DATA,
        S_PAD,
        S_FCS,
        S_IFG
    } state_t;

    localparam logic [11:0] MIN_LEN  = 12'(MIN_FRAME);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);

    // Where the frame goes after the last data/pad byte, and whether that byte ends it.
`ifdef GMII_TX_FRAMER_FCS_EN
    localparam state_t S_TAIL    = S_FCS;
    localparam logic   TAIL_DONE = 1'b0;
`else
    localparam state_t S_TAIL    = S_IFG;
    localparam logic   TAIL_DONE = 1'b1;
`endif

    state_t      state;
    logic [2:0]  pre_cnt;
    logic [7:0]  ifg_cnt;
    logic [10:0] byte_cnt;
    logic        abort_q;
    logic [11:0] cnt_p1;
    logic [10:0] cnt_nxt;

    assign cnt_p1  = {1'b0, byte_cnt} + 12'd1;
    assign cnt_nxt = cnt_p1[11] ? 11'h7FF : cnt_p1[10:0];
    assign in_rdy  = (state == S_DATA);
    assign busy    = (state != S_IDLE);

`ifdef GMII_TX_FRAMER_FCS_EN
    logic [31:0] crc;
    logic [1:0]  fcs_cnt;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state       <= S_IDLE;
            pre_cnt     <= '0;
            ifg_cnt     <= '0;
            byte_cnt    <= '0;
            abort_q     <= 1'b0;
            gmii_tx_dat <= '0;
            gmii_tx_val <= 1'b0;
            gmii_tx_err <= 1'b0;
            done        <= 1'b0;
`ifdef GMII_TX_FRAMER_FCS_EN
            crc         <= 32'hFFFFFFFF;
            fcs_cnt     <= '0;
`endif
        end else begin
            done        <= 1'b0;
            gmii_tx_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    gmii_tx_dat <= 8'h00;
                    gmii_tx_val <= 1'b0;
                    if (in_val) begin
                        state       <= S_PRE;
                        gmii_tx_dat <= 8'h55;
                        gmii_tx_val <= 1'b1;
                        pre_cnt     <= '0;
                        byte_cnt    <= '0;
                        abort_q     <= 1'b0;
`ifdef GMII_TX_FRAMER_FCS_EN
                        crc         <= 32'hFFFFFFFF;
`endif
                    end
                end
                S_PRE: begin
                    gmii_tx_dat <= 8'h55;
                    gmii_tx_val <= 1'b1;
                    pre_cnt     <= pre_cnt + 3'd1;
                    if (pre_cnt == 3'd5)
                        state <= S_SFD;
                end
                S_SFD: begin
                    gmii_tx_dat <= 8'hD5;
                    gmii_tx_val <= 1'b1;
                    state       <= S_DATA;
                end
                S_DATA: begin
                    gmii_tx_val <= 1'b1;
                    if (in_val) begin
                        gmii_tx_dat <= in_dat;
                        gmii_tx_err <= in_err;
                        byte_cnt    <= cnt_nxt;
`ifdef GMII_TX_FRAMER_FCS_EN
                        crc         <= crc_byte(crc, in_dat);
`endif
                        if (in_err) begin
                            abort_q <= 1'b1;
                            state   <= S_IFG;
                        end else if (in_last) begin
                            if (cnt_p1 < MIN_LEN) begin
                                state <= S_PAD;
                            end else begin
                                state <= S_TAIL;
                                done  <= TAIL_DONE;
                            end
                        end
                    end else begin
                        // Source starved mid-frame: poison the frame with an error byte.
                        gmii_tx_dat <= 8'h00;
                        gmii_tx_err <= 1'b1;
                        done        <= 1'b1;
                        state       <= S_IFG;
                    end
                end
                S_PAD: begin
                    gmii_tx_dat <= 8'h00;
                    gmii_tx_val <= 1'b1;
                    byte_cnt    <= cnt_nxt;
`ifdef GMII_TX_FRAMER_FCS_EN
                    crc         <= crc_byte(crc, 8'h00);
`endif
                    if (cnt_p1 >= MIN_LEN) begin
                        state <= S_TAIL;
                        done  <= TAIL_DONE;
                    end
                end
`ifdef GMII_TX_FRAMER_FCS_EN
                S_FCS: begin
                    gmii_tx_dat <= ~crc[7:0];
                    gmii_tx_val <= 1'b1;
                    crc         <= {8'h00, crc[31:8]};
                    fcs_cnt     <= fcs_cnt + 2'd1;
                    if (fcs_cnt == 2'd3) begin
                        done  <= 1'b1;
                        state <= S_IFG;
                    end
                end
`endif
                S_IFG: begin
                    gmii_tx_dat <= 8'h00;
                    if (abort_q) begin
                        gmii_tx_val <= 1'b1;
                        gmii_tx_err <= 1'b1;
                        done        <= 1'b1;
                        abort_q     <= 1'b0;
                    end else begin
                        gmii_tx_val <= 1'b0;
                        if (ifg_cnt == IFG_LAST) begin
                            ifg_cnt <= '0;
                            state   <= S_IDLE;
                        end else begin
                            ifg_cnt <= ifg_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    gmii_tx_dat <= 8'h00;
                    gmii_tx_val <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Randomized bench for gmii_tx_framer: per-cycle output stream compared against
// a frame-level model (preamble, payload, padding, table-driven CRC-32, gap).

module tb_gmii_tx_framer;

    localparam int IFG  = 12;
    localparam int MINF = 9;

    logic       clk = 1'b0;
    logic       arst;
    logic [7:0] in_dat;
    logic       in_val;
    logic       in_last;
    logic       in_err;
    logic       in_rdy;
    logic [7:0] gmii_tx_dat;
    logic       gmii_tx_val;
    logic       gmii_tx_err;
    logic       busy;
    logic       done;

    always #4 clk = ~clk;

    gmii_tx_framer #(
        .IFG_BYTES(IFG),
        .MIN_FRAME(MINF)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .in_dat     (in_dat),
        .in_val     (in_val),
        .in_last    (in_last),
        .in_err     (in_err),
        .in_rdy     (in_rdy),
        .gmii_tx_dat(gmii_tx_dat),
        .gmii_tx_val(gmii_tx_val),
        .gmii_tx_err(gmii_tx_err),
        .busy       (busy),
        .done       (done)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] crc_tab [256];
    logic [7:0]  pl [$];
    logic [11:0] exp_q [$];   // {busy, done, val, err, dat}
    logic [11:0] obs_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void init_tab();
        logic [31:0] c;
        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[i] = c;
        end
    endfunction

    function automatic logic [31:0] crc_add(input logic [31:0] c, input logic [7:0] d);
        return crc_tab[c[7:0] ^ d] ^ (c >> 8);
    endfunction

    function automatic void push_exp(input logic d, input logic v, input logic e, input logic [7:0] dat);
        exp_q.push_back({1'b1, d, v, e, dat});
    endfunction

    // kind 0: normal frame; 1: in_err on byte pos; 2: in_val dropped after pos bytes
    function automatic void build_exp(input int kind, input int pos);
        logic [31:0] c;
        int nd;
        c = 32'hFFFFFFFF;
        exp_q.delete();
        repeat (7) push_exp(1'b0, 1'b1, 1'b0, 8'h55);
        push_exp(1'b0, 1'b1, 1'b0, 8'hD5);
        if (kind == 0) begin
            foreach (pl[i]) begin
                push_exp(1'b0, 1'b1, 1'b0, pl[i]);
                c = crc_add(c, pl[i]);
            end
            for (int n = pl.size(); n < MINF; n++) begin
                push_exp(1'b0, 1'b1, 1'b0, 8'h00);
                c = crc_add(c, 8'h00);
            end
`ifdef GMII_TX_FRAMER_FCS_EN
            c = ~c;
            for (int k = 0; k < 4; k++)
                push_exp(k == 3, 1'b1, 1'b0, c[8*k +: 8]);
`else
            exp_q[exp_q.size()-1][10] = 1'b1;
`endif
        end else begin
            nd = (kind == 1) ? pos + 1 : pos;
            for (int i = 0; i < nd; i++)
                push_exp(1'b0, 1'b1, (kind == 1) && (i == pos), pl[i]);
            push_exp(1'b1, 1'b1, 1'b1, 8'h00);
        end
        for (int k = 0; k < IFG; k++)
            exp_q.push_back({(k != IFG - 1), 1'b0, 1'b0, 1'b0, 8'h00});
    endfunction

    task automatic drive(input int idx, input int lim, input int kind, input int pos, input bit hold);
        if (idx < lim) begin
            in_val  = 1'b1;
            in_dat  = pl[idx];
            in_last = (idx == pl.size() - 1);
            in_err  = (kind == 1) && (idx == pos);
        end else begin
            in_val  = hold && !in_rdy;
            in_dat  = 8'($urandom);
            in_last = 1'($urandom);
            in_err  = 1'b0;
        end
    endtask

    // Called at a falling edge with the DUT idle; ends at the falling edge of the last gap cycle.
    task automatic run_frame(input string name, input int kind, input int pos, input bit hold, input int rst_at);
        int idx;
        int lim;
        logic [11:0] got;
        idx = 0;
        lim = (kind == 0) ? pl.size() : (kind == 1) ? pos + 1 : pos;
        build_exp(kind, pos);
        obs_q.delete();
        drive(idx, lim, kind, pos, hold);
        if (in_rdy && in_val) idx++;
        for (int c = 0; c < exp_q.size(); c++) begin
            @(negedge clk);
            got = {busy, done, gmii_tx_val, gmii_tx_err, gmii_tx_dat};
            obs_q.push_back(got);
            check_eq($sformatf("%s[%0d]", name, c), 32'(got), 32'(exp_q[c]));
            if (c == rst_at) begin
                arst = 1'b1;
                #1;
                check_eq({name, "_rst_out"},
                         {22'h0, busy, done, gmii_tx_val, gmii_tx_err, in_rdy, gmii_tx_dat}, 32'h0);
                in_val  = 1'b0;
                in_last = 1'b0;
                in_err  = 1'b0;
                #1 arst = 1'b0;
                return;
            end
            drive(idx, lim, kind, pos, hold);
            if (in_rdy && in_val) idx++;
        end
    endtask

    function automatic int val_cycles();
        int n;
        n = 0;
        foreach (obs_q[i]) if (obs_q[i][9]) n++;
        return n;
    endfunction

    initial begin
        int len, kind, pos;
        bit hold;
        init_tab();
        arst    = 1'b1;
        in_val  = 1'b0;
        in_dat  = 8'h00;
        in_last = 1'b0;
        in_err  = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_val",  32'(gmii_tx_val), 32'h0);
        check_eq("rst_dat",  32'(gmii_tx_dat), 32'h0);
        check_eq("rst_busy", 32'(busy),        32'h0);
        check_eq("rst_rdy",  32'(in_rdy),      32'h0);
        arst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("idle_val", 32'(gmii_tx_val), 32'h0);

        // "123456789" padded to exactly MIN_FRAME, known CRC
        pl.delete();
        for (int i = 0; i < 9; i++) pl.push_back(8'(8'h31 + i));
        run_frame("crc9", 0, 0, 1'b0, -1);
`ifdef GMII_TX_FRAMER_FCS_EN
        check_eq("crc9_fcs", {obs_q[20][7:0], obs_q[19][7:0], obs_q[18][7:0], obs_q[17][7:0]}, 32'hCBF43926);
        check_eq("crc9_done", 32'(obs_q[20][10]), 32'h1);
        check_eq("crc9_valcyc", 32'(val_cycles()), 32'd21);
`else
        check_eq("crc9_last", 32'({obs_q[16][10], obs_q[16][7:0]}), 32'h139);
        check_eq("crc9_valcyc", 32'(val_cycles()), 32'd17);
`endif

        // single byte, padded; in_val held so the next frame follows back to back
        pl.delete();
        pl.push_back(8'hAB);
        run_frame("pad1", 0, 0, 1'b1, -1);
`ifdef GMII_TX_FRAMER_FCS_EN
        check_eq("pad1_valcyc", 32'(val_cycles()), 32'd21);
`else
        check_eq("pad1_valcyc", 32'(val_cycles()), 32'd17);
`endif
        pl.delete();
        for (int i = 0; i < 12; i++) pl.push_back(8'($urandom));
        run_frame("b2b", 0, 0, 1'b0, -1);

        // underflow after 5 bytes
        pl.delete();
        for (int i = 0; i < 8; i++) pl.push_back(8'($urandom));
        run_frame("uflow5", 2, 5, 1'b0, -1);
        check_eq("uflow5_valcyc", 32'(val_cycles()), 32'd14);

        // in_err together with in_last
        pl.delete();
        for (int i = 0; i < 4; i++) pl.push_back(8'($urandom));
        run_frame("errlast", 1, 3, 1'b0, -1);

        // reset while the third payload byte is on the wire
        pl.delete();
        for (int i = 0; i < 6; i++) pl.push_back(8'($urandom));
        run_frame("rstmid", 0, 0, 1'b0, 10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("post_rst_idle", {30'h0, gmii_tx_val, busy}, 32'h0);
        end
        pl.delete();
        for (int i = 0; i < 10; i++) pl.push_back(8'($urandom));
        run_frame("after_rst", 0, 0, 1'b0, -1);

        for (int f = 0; f < 40; f++) begin
            len  = $urandom_range(1, 20);
            kind = $urandom_range(0, 3);
            hold = 1'($urandom_range(0, 1));
            pos  = 0;
            pl.delete();
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
            if (kind == 2) begin
                kind = 1;
                pos  = $urandom_range(0, len - 1);
            end else if (kind == 3 && len >= 2) begin
                kind = 2;
                pos  = $urandom_range(1, len - 1);
            end else begin
                kind = 0;
            end
            run_frame($sformatf("rnd%0d", f), kind, pos, hold, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/gmii_tx_framer.md
GMII_TX_FRAMER -- requirements
Module: gmii_tx_framer

Interface
REQ-001 Parameter IFG_BYTES, default 12, sets the idle cycles after each frame (range 1..255).
REQ-002 Parameter MIN_FRAME, default 60, sets the minimum data+pad byte count excluding FCS (range 0..1500).
REQ-003 clk  in  1  single clock, 125 MHz GMII TX domain; all logic is on its rising edge.
REQ-004 arst  in  1  asynchronous active-high reset.
REQ-005 in_dat  in  8  payload byte, destination MAC first.
REQ-006 in_val  in  1  in_dat valid.
REQ-007 in_last  in  1  qualifies the final payload byte.
REQ-008 in_err  in  1  abort request, sampled with accepted bytes.
REQ-009 in_rdy  out  1  byte accepted when in_val && in_rdy.
REQ-010 gmii_tx_dat  out  8  registered GMII TX data.
REQ-011 gmii_tx_val  out  1  registered GMII TX enable.
REQ-012 gmii_tx_err  out  1  registered GMII TX error.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse on the cycle the last FCS byte (or abort byte) is driven.

Function
REQ-015 States: IDLE, PRE, SFD, DATA, PAD, FCS, IFG; encoding is free.
REQ-016 IDLE: on in_val=1, go to PRE without consuming the byte; next cycle gmii_tx_val=1, gmii_tx_dat=0x55.
REQ-017 PRE drives 0x55 for 7 cycles, then SFD drives 0xD5 for 1 cycle, then DATA.
REQ-018 in_rdy is asserted only in DATA; it is a pure decode of state.
REQ-019 An accepted byte appears on gmii_tx_dat exactly 1 cycle after acceptance, with gmii_tx_val=1.
REQ-020 An 11-bit byte counter increments per accepted or pad byte and saturates at 2047.
REQ-021 Accepted in_last: if count+1 < MIN_FRAME go to PAD, else go to FCS.
REQ-022 PAD drives 0x00 until the total data+pad count equals MIN_FRAME, then FCS.
REQ-023 FCS drives 4 bytes of IEEE 802.3 CRC-32 (reflected, poly 0x04C11DB7, init 0xFFFFFFFF, final inversion), LSB byte first, over all data and pad bytes (no preamble/SFD).
REQ-024 IFG holds gmii_tx_val=0, gmii_tx_err=0, gmii_tx_dat=0x00 for IFG_BYTES cycles, then IDLE; in_val is ignored during IFG.
REQ-025 Underflow: in_val=0 in DATA aborts; next cycle drives gmii_tx_val=1, gmii_tx_err=1, dat=0x00 for one cycle, pulses done, then IFG.
REQ-026 Accepted byte with in_err=1 is driven with gmii_tx_err=1; the frame then aborts as in REQ-025 without PAD or FCS.
REQ-027 in_last with in_err simultaneously: in_err wins (abort, no FCS).
REQ-028 MIN_FRAME=0: PAD is never entered.
REQ-029 gmii_tx_err is 0 in all cases not listed in REQ-025/026.

Reset
REQ-030 arst asserted forces state IDLE, counters 0, CRC 0xFFFFFFFF, all outputs 0, immediately and asynchronously.
REQ-031 arst mid-frame truncates the frame with no error byte; after release, the first frame starts only on a new in_val.
REQ-032 arst deassertion is synchronised externally; the block adds no deassertion synchroniser.

Configuration
REQ-033 Macro GMII_TX_FRAMER_FCS_EN defined: CRC logic is present and the FCS state operates per REQ-023.
REQ-034 Macro absent: no CRC logic; DATA/PAD transitions go directly to IFG; done pulses on the last data/pad byte; padding is unchanged.

Verification
REQ-035 MIN_FRAME=9, payload ASCII "123456789" then in_last -> 7x0x55, 0xD5, 31..39, 0x26 0x39 0xF4 0xCB; gmii_tx_val high for 21 cycles, done on the 0xCB cycle.
REQ-036 Defaults, 1-byte payload 0xAB -> 0xAB followed by 59x0x00, then 4 FCS bytes; gmii_tx_val high for 72 contiguous cycles.
REQ-037 Back-to-back frames with in_val held high -> exactly 12 cycles of gmii_tx_val=0 between last FCS byte and next 0x55.
REQ-038 in_val dropped after 5 payload bytes -> 5 bytes driven, then one cycle with val=1/err=1, done pulse, 12 idle cycles, no FCS.
REQ-039 arst pulsed during the 3rd payload byte -> outputs 0 within the same cycle, busy=0; next frame is well-formed with correct FCS.
REQ-040 Macro undefined, "123456789", MIN_FRAME=9 -> 17 val cycles ending at 0x39, done on 0x39.
